// File: rtl/mac_result_serializer.sv
// Buffers 16-bit MAC results in a word FIFO and streams them as byte pairs.
// Optional MAC_SER_PARITY_EN adds out_parity (XOR of out_data).
module mac_result_serializer #(
    parameter int DEPTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [15:0]                  in_data,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic [7:0]                   out_data,
    output logic                         out_last,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         overflow,
    input  logic                         ovf_clr
`ifdef MAC_SER_PARITY_EN
    ,
    output logic                         out_parity
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BYTE0,
        S_BYTE1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [15:0]     r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [15:0]     r_hold;
    logic            r_ovf;

    logic            w_full;
    logic            w_not_empty;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic [7:0]      w_first;
    logic [7:0]      w_second;

    assign w_full      = (r_count == CW'(DEPTH));
    assign w_not_empty = (r_count != '0);

    // A full FIFO still accepts a word when the head leaves on the same edge
    assign w_push = in_valid && (!w_full || w_pop);
    assign w_drop = in_valid && w_full && !w_pop;

    assign w_first  = MSB_FIRST ? r_hold[15:8] : r_hold[7:0];
    assign w_second = MSB_FIRST ? r_hold[7:0]  : r_hold[15:8];

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        out_data    = 8'h00;
        unique case (r_state)
            S_IDLE: begin
                if (w_not_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_BYTE0;
                end
            end
            S_BYTE0: begin
                out_valid = 1'b1;
                out_data  = w_first;
                if (out_ready) begin
                    w_state_nxt = S_BYTE1;
                end
            end
            S_BYTE1: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                out_data  = w_second;
                if (out_ready) begin
                    if (w_not_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = S_BYTE0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Storage array needs no reset; pointers and count define validity
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_hold   <= 16'h0000;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
                r_hold   <= r_mem[r_rd_ptr];
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A drop on the same edge as a clear keeps the flag set
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign fifo_count = r_count;
    assign overflow   = r_ovf;

`ifdef MAC_SER_PARITY_EN
    assign out_parity = ^out_data;
`endif

endmodule

// File: doc/mac_result_serializer.md
Name: mac_result_serializer

Overview:
- Downstream stage of mac_unit: captures each 16-bit accumulator result (c) on its valid pulse and streams it out as two bytes over a ready/valid byte interface.
- Buffers results in a small word FIFO so that bursts of MAC results survive a stalled consumer.
- Drops results on overflow and records the drop in a sticky flag.
- Sits between mac_unit and the pin-level wrapper, which drives the 8-bit output bus.

Parameters:
- DEPTH, 4, FIFO depth in 16-bit words; power of 2, ≥2.
- MSB_FIRST, 1, 1 = high byte sent first, 0 = low byte first.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  one-cycle strobe from mac_unit valid
- in_data  in  16  mac_unit result c
- out_ready  in  1  consumer accepts out_data this cycle
- out_valid  out  1  out_data holds a valid byte
- out_data  out  8  current byte
- out_last  out  1  high on the second byte of a word
- fifo_count  out  $clog2(DEPTH+1)  words stored in the FIFO, excluding the word being sent
- overflow  out  1  sticky: a result was dropped
- ovf_clr  in  1  synchronous clear of overflow

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: while reset is high, all state clears immediately: FIFO pointers, count, hold register, FSM=IDLE. Outputs are out_valid=0, out_data=0, out_last=0, fifo_count=0, overflow=0.
- Reset asserted mid-word abandons that word and all queued words; no partial byte is emitted after reset releases.
- FIFO push and drop:
  - A push occurs on an edge where in_valid=1 and the FIFO is not full. The word is written at wr_ptr, and wr_ptr wraps modulo DEPTH.
  - in_valid=1 while full and no pop on the same edge: the word is dropped and overflow is set.
  - in_valid=1 while full with a pop on the same edge: the push is accepted and count is unchanged.
- FIFO pop: occurs when the FSM loads the hold register. rd_ptr wraps modulo DEPTH.
- fifo_count: +1 on push only, −1 on pop only, unchanged on both or neither.
- FSM states are IDLE, BYTE0 and BYTE1.
  - IDLE: if count>0, pop head into hold and go to BYTE0. Otherwise stay.
  - BYTE0: out_valid=1, out_last=0, out_data = first byte (hold[15:8] if MSB_FIRST, else hold[7:0]). On out_ready, go to BYTE1. Otherwise hold.
  - BYTE1: out_valid=1, out_last=1, out_data = second byte. On out_ready: if count>0, pop into hold and go to BYTE0 (no bubble). Otherwise go to IDLE.
- Handshake rule: out_data, out_last and out_valid stay stable while out_valid=1 and out_ready=0.
- Latency:
  - A word pushed at edge k into an empty FIFO with FSM in IDLE is popped at edge k+1; out_valid=1 after edge k+1.
  - Sustained throughput is 1 word per 2 cycles with out_ready held high.
- Bypass: none; every word passes through the FIFO.
- overflow: set on a drop, cleared by ovf_clr. If a set and ovf_clr occur on the same edge, set wins.
- Outputs are registered (FSM/hold based); there is no combinational path from in_* to out_*.
- ena/enable gating is handled upstream; this block always runs.

Optional Feature:
- Macro: MAC_SER_PARITY_EN.
- With the macro defined:
  - An extra output out_parity (1 bit) is present, equal to the even parity of out_data (XOR of its 8 bits).
  - out_parity is valid whenever out_valid=1 and is 0 in reset.
- Without the macro: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Single word, MSB_FIRST=1:
  - Stimulus: after reset, in_valid pulse with in_data=16'hA55A; out_ready=1.
  - Response: out_valid rises after edge k+1; bytes 8'hA5 (last=0) then 8'h5A (last=1); then out_valid=0 and fifo_count=0.
- Backpressure:
  - Stimulus: push 16'h1234 with out_ready=0 for 5 cycles, then out_ready=1.
  - Response: out_data=8'h12 held stable for all stalled cycles, then 8'h12, 8'h34; no duplication.
- Overflow with DEPTH=4:
  - Stimulus: out_ready=0; push 6 words 16'h0001..16'h0006 on consecutive cycles.
  - Response: word 1 goes to hold, words 2-5 fill the FIFO (fifo_count=4), word 6 is dropped and overflow=1.
  - Continuation: releasing out_ready yields words 1-5 in order. Asserting ovf_clr afterwards gives overflow=0.
- Back-to-back streaming:
  - Stimulus: 8 words pushed every other cycle with out_ready=1.
  - Response: continuous out_valid=1 with no IDLE bubble; byte order is correct and pointers wrap past DEPTH.
- Reset mid-word:
  - Stimulus: assert reset while in BYTE0 with fifo_count=2.
  - Response: out_valid=0 and fifo_count=0 immediately, without waiting for a clock edge; after release, no stale bytes are emitted.
- Ordering and parity:
  - Stimulus: MSB_FIRST=0 with MAC_SER_PARITY_EN defined; push 16'h0F01.
  - Response: bytes 8'h01 (parity 1) then 8'h0F (parity 0).
